fast_spi_peripheral: RTL and testbench



---
 rtl/fast_spi_peripheral_if.sv | 25 ++
 rtl/fast_spi_peripheral.sv | 191 +++++++++++++++++++
 tb/tb_fast_spi_peripheral.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fast_spi_peripheral_if.sv
// Pin and core-side bundle for fast_spi_peripheral: SPI pins plus the parallel word exchange.
interface fast_spi_peripheral_if #(
    parameter int FRAME_BITS = 24
);
    logic                  sck;
    logic                  cs;
    logic                  sdi;
    logic                  sdo;
    logic                  sdo_oe;
    logic [FRAME_BITS-1:0] tx_data;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  rx_valid;
    logic                  abort;
    logic                  busy;

    modport master (
        output sck, cs, sdi, tx_data,
        input  sdo, sdo_oe, rx_data, rx_valid, abort, busy
    );

    modport slave (
        input  sck, cs, sdi, tx_data,
        output sdo, sdo_oe, rx_data, rx_valid, abort, busy
    );
endinterface

// File: rtl/fast_spi_peripheral.sv
// Mode-0 MSB-first SPI target with all pins oversampled in the clk domain.
// FAST_SPI_PERIPH_SYNC3_EN selects 3-flop pin synchronizers instead of 2.
module fast_spi_peripheral #(
    parameter int FRAME_BITS = 24,
    parameter int CNT_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    fast_spi_peripheral_if.slave bus
);
`ifdef FAST_SPI_PERIPH_SYNC3_EN
    localparam int SYNC_DEPTH = 3;
`else
    localparam int SYNC_DEPTH = 2;
`endif
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_BITS);
    localparam logic [2:0]       FLUSH_CNT = 3'(SYNC_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE    = 2'd2,
        WAIT_CS = 2'd3
    } state_t;

    logic [SYNC_DEPTH-1:0] sck_pipe_r;
    logic [SYNC_DEPTH-1:0] cs_pipe_r;
    logic [SYNC_DEPTH-1:0] sdi_pipe_r;
    logic                  sck_d_r;
    logic                  cs_d_r;
    logic [2:0]            flush_cnt_r;
    logic                  armed_r;

    logic sck_sync_s, cs_sync_s, sdi_sync_s;
    logic sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;

    state_t                state_r, state_nx_s;
    logic [FRAME_BITS-1:0] tx_shift_r, tx_shift_nx_s;
    logic [FRAME_BITS-1:0] rx_shift_r, rx_shift_nx_s;
    logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_nx_s;
    logic [FRAME_BITS-1:0] rx_data_r, rx_data_nx_s;
    logic                  rx_valid_r, rx_valid_nx_s;
    logic                  abort_r, abort_nx_s;
    logic                  sdo_r, sdo_oe_r, busy_r;

    // Pin synchronizers plus one extra stage per line for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_pipe_r <= {SYNC_DEPTH{1'b0}};
            cs_pipe_r  <= {SYNC_DEPTH{1'b1}};
            sdi_pipe_r <= {SYNC_DEPTH{1'b0}};
            sck_d_r    <= 1'b0;
            cs_d_r     <= 1'b1;
        end else begin
            sck_pipe_r <= {sck_pipe_r[SYNC_DEPTH-2:0], bus.sck};
            cs_pipe_r  <= {cs_pipe_r[SYNC_DEPTH-2:0], bus.cs};
            sdi_pipe_r <= {sdi_pipe_r[SYNC_DEPTH-2:0], bus.sdi};
            sck_d_r    <= sck_sync_s;
            cs_d_r     <= cs_sync_s;
        end
    end

    assign sck_sync_s = sck_pipe_r[SYNC_DEPTH-1];
    assign cs_sync_s  = cs_pipe_r[SYNC_DEPTH-1];
    assign sdi_sync_s = sdi_pipe_r[SYNC_DEPTH-1];

    assign sck_rise_s = sck_sync_s & ~sck_d_r;
    assign sck_fall_s = ~sck_sync_s & sck_d_r;
    assign cs_rise_s  = cs_sync_s & ~cs_d_r;
    // The reset value of the cs flops must not fake a falling edge, so a frame
    // may only start once cs has genuinely been seen high after reset.
    assign cs_fall_s  = ~cs_sync_s & cs_d_r & armed_r;

    // Arm frame start once the synchronizer has flushed and cs reads high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_r <= 3'd0;
            armed_r     <= 1'b0;
        end else begin
            if (flush_cnt_r != FLUSH_CNT) begin
                flush_cnt_r <= flush_cnt_r + 3'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
            if ((flush_cnt_r == FLUSH_CNT) && cs_sync_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and datapath decode; cs_rise outranks any same-cycle sck edge.
    always_comb begin
        state_nx_s    = state_r;
        tx_shift_nx_s = tx_shift_r;
        rx_shift_nx_s = rx_shift_r;
        bit_cnt_nx_s  = bit_cnt_r;
        rx_data_nx_s  = rx_data_r;
        rx_valid_nx_s = 1'b0;
        abort_nx_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s) begin
                    tx_shift_nx_s = bus.tx_data;
                    rx_shift_nx_s = {FRAME_BITS{1'b0}};
                    bit_cnt_nx_s  = {CNT_W{1'b0}};
                    state_nx_s    = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_r == FULL_CNT) begin
                    state_nx_s = DONE;
                end else if (cs_rise_s) begin
                    abort_nx_s = 1'b1;
                    state_nx_s = IDLE;
                end else if (sck_rise_s) begin
                    rx_shift_nx_s = {rx_shift_r[FRAME_BITS-2:0], sdi_sync_s};
                    bit_cnt_nx_s  = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (sck_fall_s) begin
                    tx_shift_nx_s = {tx_shift_r[FRAME_BITS-2:0], 1'b0};
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                rx_data_nx_s  = rx_shift_r;
                rx_valid_nx_s = 1'b1;
                if (cs_rise_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_CS;
                end
            end
            WAIT_CS: begin
                if (cs_rise_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_CS;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Datapath and output registers; outputs are derived from next-state so
    // they land on the same edge as the state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_r <= {FRAME_BITS{1'b0}};
            rx_shift_r <= {FRAME_BITS{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            rx_data_r  <= {FRAME_BITS{1'b0}};
            rx_valid_r <= 1'b0;
            abort_r    <= 1'b0;
            sdo_r      <= 1'b0;
            sdo_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            tx_shift_r <= tx_shift_nx_s;
            rx_shift_r <= rx_shift_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            rx_data_r  <= rx_data_nx_s;
            rx_valid_r <= rx_valid_nx_s;
            abort_r    <= abort_nx_s;
            sdo_r      <= (state_nx_s == SHIFT) ? tx_shift_nx_s[FRAME_BITS-1] : 1'b0;
            sdo_oe_r   <= ~cs_sync_s;
            busy_r     <= (state_nx_s == SHIFT) || (state_nx_s == DONE);
        end
    end

    assign bus.sdo      = sdo_r;
    assign bus.sdo_oe   = sdo_oe_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.abort    = abort_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_fast_spi_peripheral.sv
// Directed bench for fast_spi_peripheral: a behavioural SPI controller at f_clk/8.
module tb_fast_spi_peripheral;
    logic clk;
    logic rst;

    fast_spi_peripheral_if #(.FRAME_BITS(24)) bus_if ();

    fast_spi_peripheral #(.FRAME_BITS(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    int          rv_pulses  = 0;
    int          rv_cycles  = 0;
    int          ab_pulses  = 0;
    logic        rv_prev    = 1'b0;
    logic        ab_prev    = 1'b0;
    logic [23:0] rx_log [0:15];
    int          rx_log_n   = 0;
    int          busy_drops = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled on the inactive clock edge.
    always @(negedge clk) begin
        if (bus_if.rx_valid) begin
            rv_cycles = rv_cycles + 1;
            if (!rv_prev) begin
                rv_pulses = rv_pulses + 1;
                if (rx_log_n < 16) begin
                    rx_log[rx_log_n] = bus_if.rx_data;
                    rx_log_n = rx_log_n + 1;
                end
            end
        end
        if (bus_if.abort && !ab_prev) begin
            ab_pulses = ab_pulses + 1;
        end
        rv_prev = bus_if.rx_valid;
        ab_prev = bus_if.abort;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Controller frame: cs low, nrise sck cycles, optionally raise cs and wait gap clocks.
    task automatic spi_xfer(input logic [23:0] mosi, input int nrise, input int chg_at,
                            input bit raise_cs, input int gap, output logic [63:0] miso);
        miso = 64'd0;
        @(negedge clk);
        bus_if.cs = 1'b0;
        for (int i = 0; i < nrise; i++) begin
            bus_if.sdi = (i < 24) ? mosi[23 - i] : 1'b1;
            if (i == chg_at) begin
                bus_if.tx_data = 24'hFFFFFF;
            end
            repeat (4) @(negedge clk);
            miso = {miso[62:0], bus_if.sdo};
            if (!bus_if.busy) begin
                busy_drops = busy_drops + 1;
            end
            bus_if.sck = 1'b1;
            repeat (4) @(negedge clk);
            bus_if.sck = 1'b0;
        end
        if (raise_cs) begin
            repeat (4) @(negedge clk);
            bus_if.cs = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] miso;
        int rv0, rc0, ab0;

        rst            = 1'b1;
        bus_if.sck     = 1'b0;
        bus_if.cs      = 1'b1;
        bus_if.sdi     = 1'b0;
        bus_if.tx_data = 24'h000000;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {59'd0, bus_if.sdo, bus_if.sdo_oe, bus_if.rx_valid, bus_if.abort, bus_if.busy}, 64'd0);
        check_eq("rst_rx_data", {40'd0, bus_if.rx_data}, 64'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Nominal frame.
        bus_if.tx_data = 24'hA5C3F0;
        rv0 = rv_pulses; rc0 = rv_cycles; ab0 = ab_pulses;
        spi_xfer(24'h123456, 24, -1, 1'b1, 8, miso);
        check_eq("nom_miso", {40'd0, miso[23:0]}, 64'h0000_0000_00A5_C3F0);
        check_eq("nom_rx_data", {40'd0, bus_if.rx_data}, 64'h123456);
        check_eq("nom_rv_pulses", 64'(rv_pulses - rv0), 64'd1);
        check_eq("nom_rv_cycles", 64'(rv_cycles - rc0), 64'd1);
        check_eq("nom_abort", 64'(ab_pulses - ab0), 64'd0);

        // Short frame aborts and keeps the previous word.
        rv0 = rv_pulses; ab0 = ab_pulses;
        spi_xfer(24'hFEDCBA, 10, -1, 1'b1, 8, miso);
        check_eq("short_abort", 64'(ab_pulses - ab0), 64'd1);
        check_eq("short_rv", 64'(rv_pulses - rv0), 64'd0);
        check_eq("short_rx_hold", {40'd0, bus_if.rx_data}, 64'h123456);
        check_eq("short_idle_busy", {63'd0, bus_if.busy}, 64'd0);

        // Extra sck cycles after a complete frame.
        bus_if.tx_data = 24'h6B2D91;
        rv0 = rv_pulses; ab0 = ab_pulses;
        spi_xfer(24'h0A0B0C, 30, -1, 1'b1, 8, miso);
        check_eq("extra_miso_head", {40'd0, miso[29:6]}, 64'h6B2D91);
        check_eq("extra_miso_tail", {58'd0, miso[5:0]}, 64'd0);
        check_eq("extra_rv", 64'(rv_pulses - rv0), 64'd1);
        check_eq("extra_abort", 64'(ab_pulses - ab0), 64'd0);
        check_eq("extra_rx_data", {40'd0, bus_if.rx_data}, 64'h0A0B0C);

        // tx_data changed mid-frame must not disturb the captured word.
        bus_if.tx_data = 24'h3C5A96;
        busy_drops = 0;
        spi_xfer(24'h777111, 24, 5, 1'b1, 8, miso);
        check_eq("stable_miso", {40'd0, miso[23:0]}, 64'h3C5A96);
        check_eq("stable_busy", 64'(busy_drops), 64'd0);
        check_eq("stable_rx_data", {40'd0, bus_if.rx_data}, 64'h777111);

        // Reset in the middle of a frame with cs held low.
        bus_if.tx_data = 24'h0F0F0F;
        rv0 = rv_pulses; ab0 = ab_pulses;
        spi_xfer(24'hABCDEF, 12, -1, 1'b0, 0, miso);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("midrst_outs", {59'd0, bus_if.sdo, bus_if.sdo_oe, bus_if.rx_valid, bus_if.abort, bus_if.busy}, 64'd0);
        check_eq("midrst_rx_data", {40'd0, bus_if.rx_data}, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat (4) @(negedge clk);
            bus_if.sck = 1'b1;
            repeat (4) @(negedge clk);
            bus_if.sck = 1'b0;
        end
        repeat (4) @(negedge clk);
        check_eq("postrst_rv", 64'(rv_pulses - rv0), 64'd0);
        check_eq("postrst_abort", 64'(ab_pulses - ab0), 64'd0);
        check_eq("postrst_busy", {63'd0, bus_if.busy}, 64'd0);
        bus_if.cs = 1'b1;
        repeat (8) @(negedge clk);
        spi_xfer(24'h5A5A5A, 24, -1, 1'b1, 8, miso);
        check_eq("postrst_miso", {40'd0, miso[23:0]}, 64'h0F0F0F);
        check_eq("postrst_rx_data", {40'd0, bus_if.rx_data}, 64'h5A5A5A);

        // Back-to-back frames with a 4-clock cs-high gap.
        rv0 = rv_pulses;
        rc0 = rx_log_n;
        spi_xfer(24'h000001, 24, -1, 1'b1, 4, miso);
        spi_xfer(24'h800000, 24, -1, 1'b1, 8, miso);
        check_eq("b2b_rv", 64'(rv_pulses - rv0), 64'd2);
        check_eq("b2b_first", {40'd0, rx_log[rc0]}, 64'h000001);
        check_eq("b2b_second", {40'd0, rx_log[rc0 + 1]}, 64'h800000);
        check_eq("b2b_rv_width", 64'(rv_cycles), 64'(rv_pulses));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
